// File: rtl/decode_alu_stage.sv
// decode_alu_stage
//   Registered, handshaked ALU-instruction decode stage. Decodes R-type
//   (opcode 0110011) and, when ENABLE_ITYPE=1, I-type ALU (opcode 0010011)
//   instructions into register indices, a sign-extended immediate, an ALU
//   operation code and an illegal flag. Decoded entries go into a 2-entry
//   FIFO whose head drives the outputs.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   flush                  synchronous drop of all buffered entries
//   in_valid/in_ready      input handshake, instruction_code is the raw word
//   out_valid/out_ready    output handshake for the head entry
//   rs1/rs2/rd             register indices
//   imm                    sign-extended I-immediate (0 for R-type/illegal)
//   use_imm                ALU operand B comes from imm
//   rd_we                  write rd (0 when illegal or rd==0)
//   alu_control            ALU operation code
//   illegal                unsupported encoding
//   illegal_count          saturating count of accepted illegal instructions
module decode_alu_stage #(
  parameter int XLEN         = 32,
  parameter int ALU_CTRL_W   = 5,
  parameter int ENABLE_ITYPE = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       imm,
  output logic                  use_imm,
  output logic                  rd_we,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [CNT_W-1:0]      illegal_count
);

  // ALU operation codes shared with the processor's ALU.
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(9);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_A = 7'b0100000;

  typedef struct packed {
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [XLEN-1:0]       imm;
    logic                  use_imm;
    logic                  rd_we;
    logic [ALU_CTRL_W-1:0] alu;
    logic                  illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  assign opcode = instruction_code[6:0];
  assign func3  = instruction_code[14:12];
  assign func7  = instruction_code[31:25];

  entry_t                dec;
  logic                  legal;
  logic                  is_itype;
  logic [ALU_CTRL_W-1:0] alu_sel;

  // func3 -> operation for the encodings shared by R- and I-type; the
  // func7-dependent variants are resolved below.
  always_comb begin
    alu_sel = ALU_ADD;
    case (func3)
      3'b000: alu_sel = ALU_ADD;
      3'b001: alu_sel = ALU_SLL;
      3'b010: alu_sel = ALU_SLT;
      3'b011: alu_sel = ALU_SLTU;
      3'b100: alu_sel = ALU_XOR;
      3'b101: alu_sel = ALU_SRL;
      3'b110: alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  end

  always_comb begin
    legal    = 1'b0;
    is_itype = 1'b0;
    dec      = '0;
    dec.rs1  = instruction_code[19:15];
    dec.rs2  = instruction_code[24:20];
    dec.rd   = instruction_code[11:7];
    dec.alu  = ALU_ADD;

    if (opcode == OP_R) begin
      if (func7 == F7_0) begin
        legal   = 1'b1;
        dec.alu = alu_sel;
      end else if (func7 == F7_A && func3 == 3'b000) begin
        legal   = 1'b1;
        dec.alu = ALU_SUB;
      end else if (func7 == F7_A && func3 == 3'b101) begin
        legal   = 1'b1;
        dec.alu = ALU_SRA;
      end
    end else if (opcode == OP_I && ENABLE_ITYPE != 0) begin
      is_itype = 1'b1;
      dec.alu  = alu_sel;
      case (func3)
        3'b001: legal = (func7 == F7_0);
        3'b101: begin
          legal = (func7 == F7_0) || (func7 == F7_A);
          if (func7 == F7_A) dec.alu = ALU_SRA;
        end
        default: legal = 1'b1;
      endcase
    end

    if (legal) begin
      dec.rd_we = (dec.rd != 5'd0);
      if (is_itype) begin
        dec.use_imm = 1'b1;
        dec.imm     = {{(XLEN-12){instruction_code[31]}}, instruction_code[31:20]};
        dec.rs2     = 5'd0;
      end
    end else begin
      // Raw register fields stay visible; everything else collapses to a
      // harmless ADD with no writeback.
      dec.illegal = 1'b1;
      dec.alu     = ALU_ADD;
      dec.rd_we   = 1'b0;
      dec.use_imm = 1'b0;
      dec.imm     = '0;
    end
  end

  // 2-entry FIFO of decoded entries
  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  entry_t     head;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      illegal_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
      // The counter survives flush; only accepted instructions count.
      if (push && dec.illegal && illegal_count != '1)
        illegal_count <= illegal_count + CNT_W'(1);
    end
  end

  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign rd          = head.rd;
  assign imm         = head.imm;
  assign use_imm     = head.use_imm;
  assign rd_we       = head.rd_we;
  assign alu_control = head.alu;
  assign illegal     = head.illegal;

endmodule

// File: tb/tb_decode_alu_stage.sv
module tb_decode_alu_stage;

  localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd2, A_SLT = 5'd3,
                         A_SLTU = 5'd4, A_XOR = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7,
                         A_OR = 5'd8, A_AND = 5'd9;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instruction_code;

  logic        in_ready, out_valid, use_imm, rd_we, illegal;
  logic [4:0]  rs1, rs2, rd, alu_control;
  logic [31:0] imm;
  logic [15:0] illegal_count;

  logic        in_ready2, out_valid2, use_imm2, rd_we2, illegal2;
  logic [4:0]  rs1_2, rs2_2, rd_2, alu_control2;
  logic [31:0] imm2;
  logic [1:0]  illegal_count2;

  always #5 clk = ~clk;

  decode_alu_stage #(.XLEN(32), .ALU_CTRL_W(5), .ENABLE_ITYPE(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_code(instruction_code), .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm), .rd_we(rd_we),
    .alu_control(alu_control), .illegal(illegal), .illegal_count(illegal_count));

  // No I-type support and a tiny counter, to exercise the illegal path and saturation.
  decode_alu_stage #(.XLEN(32), .ALU_CTRL_W(5), .ENABLE_ITYPE(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .instruction_code(instruction_code), .out_valid(out_valid2), .out_ready(out_ready),
    .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .imm(imm2), .use_imm(use_imm2), .rd_we(rd_we2),
    .alu_control(alu_control2), .illegal(illegal2), .illegal_count(illegal_count2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit [4:0]  rs1, rs2, rd, alu;
    bit [31:0] imm;
    bit        use_imm, rd_we, ill;
  } exp_t;

  // Reference decode written from the instruction-set rules.
  function automatic exp_t ref_dec(input bit [31:0] ins, input bit itype_en);
    exp_t     e;
    bit [4:0] base [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    bit [6:0] op = ins[6:0];
    bit [6:0] f7 = ins[31:25];
    bit [2:0] f3 = ins[14:12];
    bit       ok;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.imm = 0; e.use_imm = 0; e.alu = A_ADD; e.ill = 1; e.rd_we = 0;
    if (op == 7'h33) begin
      if (f7 == 0)                      begin e.ill = 0; e.alu = base[f3]; end
      else if (f7 == 7'h20 && f3 == 0)  begin e.ill = 0; e.alu = A_SUB;   end
      else if (f7 == 7'h20 && f3 == 5)  begin e.ill = 0; e.alu = A_SRA;   end
    end else if (op == 7'h13 && itype_en) begin
      ok = 1; e.alu = base[f3];
      if (f3 == 1 && f7 != 0) ok = 0;
      if (f3 == 5) begin
        if (f7 == 7'h20) e.alu = A_SRA;
        else if (f7 != 0) ok = 0;
      end
      if (ok) begin
        e.ill = 0; e.use_imm = 1; e.rs2 = 0;
        e.imm = {{20{ins[31]}}, ins[31:20]};
      end else e.alu = A_ADD;
    end
    if (!e.ill) e.rd_we = (e.rd != 0);
    return e;
  endfunction

  bit [31:0]   q[$];
  int unsigned cnt1 = 0, cnt2 = 0;
  bit          accepted;

  task automatic model_update();
    bit acc, del;
    acc = in_valid && (q.size() < 2) && !flush;
    del = (q.size() > 0) && out_ready;
    if (flush) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) begin
        q.push_back(instruction_code);
        if (ref_dec(instruction_code, 1).ill && cnt1 < 65535) cnt1++;
        if (ref_dec(instruction_code, 0).ill && cnt2 < 3) cnt2++;
      end
    end
    accepted = acc;
  endtask

  task automatic compare_all();
    exp_t e;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("illegal_count", illegal_count, cnt1);
    chk("out_valid2", out_valid2, q.size() > 0);
    chk("in_ready2", in_ready2, q.size() < 2);
    chk("illegal_count2", illegal_count2, cnt2);
    if (q.size() > 0) begin
      e = ref_dec(q[0], 1);
      chk("rs1", rs1, e.rs1); chk("rs2", rs2, e.rs2); chk("rd", rd, e.rd);
      chk("imm", imm, e.imm); chk("use_imm", use_imm, e.use_imm);
      chk("rd_we", rd_we, e.rd_we); chk("alu", alu_control, e.alu);
      chk("illegal", illegal, e.ill);
      e = ref_dec(q[0], 0);
      chk("rs1_2", rs1_2, e.rs1); chk("rs2_2", rs2_2, e.rs2); chk("rd_2", rd_2, e.rd);
      chk("imm2", imm2, e.imm); chk("use_imm2", use_imm2, e.use_imm);
      chk("rd_we2", rd_we2, e.rd_we); chk("alu2", alu_control2, e.alu);
      chk("illegal2", illegal2, e.ill);
    end
  endtask

  // Inputs change only at negedge; the model advances on the same posedge as the DUT.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push_one(input logic [31:0] ins);
    in_valid = 1'b1;
    instruction_code = ins;
    cyc();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      ins[6:0] = 7'h33;
    else if (k < 8) ins[6:0] = 7'h13;
    k = $urandom_range(0, 3);
    if (k == 0)      ins[31:25] = 7'h00;
    else if (k == 1) ins[31:25] = 7'h20;
    else if (k == 2) ins[31:25] = 7'h00;
    return ins;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction_code = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst illegal_count", illegal_count, 0);
    chk("rst outputs", {rs1, rs2, rd, imm, use_imm, rd_we, alu_control, illegal}, 0);
    cyc();

    // Directed decodes, consumer always ready
    out_ready = 1'b1;
    push_one(32'h40208033);
    chk("sub out_valid", out_valid, 1); chk("sub alu", alu_control, A_SUB);
    chk("sub rs1", rs1, 1); chk("sub rs2", rs2, 2); chk("sub rd", rd, 0);
    chk("sub rd_we", rd_we, 0);
    push_one(32'hFFF08093);
    chk("addi alu", alu_control, A_ADD); chk("addi use_imm", use_imm, 1);
    chk("addi imm", imm, 32'hFFFF_FFFF); chk("addi rd", rd, 1);
    chk("addi rd_we", rd_we, 1); chk("addi illegal", illegal, 0);
    chk("addi illegal2", illegal2, 1);
    push_one(32'h4030D093);
    chk("srai alu", alu_control, A_SRA); chk("srai imm", imm, 32'h403);
    push_one(32'h02208033);
    chk("mul illegal", illegal, 1); chk("mul rd_we", rd_we, 0);
    chk("mul count", illegal_count, 1);
    push_one(32'h02208033);
    chk("sat count2", illegal_count2, 3);
    chk("count after 2 mul", illegal_count, 2);
    cyc();
    chk("drained out_valid", out_valid, 0);

    // Backpressure: three back-to-back pushes with consumer stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_code = 32'h00A00133;  // add x2,x0,x10
    cyc();
    instruction_code = 32'h00B001B3;  // add x3,x0,x11
    cyc();
    chk("bp in_ready full", in_ready, 0);
    instruction_code = 32'h00C00233;  // add x4,x0,x12
    cyc();
    chk("bp held out_valid", out_valid, 1);
    chk("bp head rd", rd, 2);
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) cyc();
    chk("bp third accepted", accepted, 1);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("bp drained", out_valid, 0);

    // Flush while full, with a simultaneous input that must be dropped
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_code = 32'h00A00133; cyc();
    instruction_code = 32'h00B001B3; cyc();
    flush = 1'b1;
    instruction_code = 32'h00C00233; cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    chk("flush nothing delivered", out_valid, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_code = 32'hFFF08093; cyc();
    instruction_code = 32'h02208033; cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst count", illegal_count, 0);
    chk("midrst outputs", {rs1, rs2, rd, imm, use_imm, rd_we, alu_control, illegal}, 0);
    q.delete(); cnt1 = 0; cnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      instruction_code = rand_instr();
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
